// File: rtl/ahb_slave_arbiter_gen.sv
// -----------------------------------------------------------------------------
// ahb_slave_arbiter_gen
//
// Per-slave AHB arbiter for the generated bus. Chooses which master owns the
// address phase of this slave port and keeps that owner for the whole of a
// fixed-length or undefined-length (INCR) burst.
//
// Arbitration modes (ARB_MODE):
//   0 : fixed priority, highest hprior wins, ties go to the lowest index
//   1 : round-robin, hprior ignored
//   2 : highest hprior wins, ties resolved by the round-robin search
//
// Ports:
//   hclk          bus clock
//   hreset_n      synchronous active-low reset
//   hreq          per-master request lines
//   hprior        packed priorities, [i*PRIO_W +: PRIO_W] belongs to master i
//   htrans_in     htrans of the currently granted master
//   hburst_in     hburst of the currently granted master
//   hready_in     slave hreadyout; 1 = address phase accepted this cycle
//   hgrant        one-hot address-phase grant (registered, mux select)
//   hsel          slave select, OR of hgrant
//   hgrant_data   one-hot data-phase grant (hgrant one accepted phase later)
//   hmaster       encoded index of hgrant, 0 when nothing is granted
//   burst_locked  1 while a burst suppresses arbitration
// -----------------------------------------------------------------------------
module ahb_slave_arbiter_gen #(
  parameter int NUM_MASTERS    = 4,
  parameter int PRIO_W         = 2,
  parameter int ARB_MODE       = 2,
  parameter int INCR_MAX_BEATS = 16,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          hclk,
  input  logic                          hreset_n,
  input  logic [NUM_MASTERS-1:0]        hreq,
  input  logic [NUM_MASTERS*PRIO_W-1:0] hprior,
  input  logic [1:0]                    htrans_in,
  input  logic [2:0]                    hburst_in,
  input  logic                          hready_in,
  output logic [NUM_MASTERS-1:0]        hgrant,
  output logic                          hsel,
  output logic [NUM_MASTERS-1:0]        hgrant_data,
  output logic [MW-1:0]                 hmaster,
  output logic                          burst_locked
);

  // Counter must hold the 16-beat load value and count up to INCR_MAX_BEATS.
  localparam int CNT_W = $clog2((INCR_MAX_BEATS > 16) ? INCR_MAX_BEATS : 16) + 1;
  // An accepted INCR SEQ seen with this count reaches INCR_MAX_BEATS.
  localparam logic [CNT_W-1:0] INCR_LAST = CNT_W'(INCR_MAX_BEATS - 1);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BU_SINGLE = 3'b000;
  localparam logic [2:0] BU_INCR   = 3'b001;

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_MASTERS-1:0]  grant_q, grant_d;
  logic [NUM_MASTERS-1:0]  grant_data_q, grant_data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    lock_incr_q, lock_incr_d;
  logic [MW-1:0]           rr_ptr_q, rr_ptr_d;

  // Winner of the current request pattern.
  logic [PRIO_W-1:0]       max_prio;
  logic [NUM_MASTERS-1:0]  cand;
  logic [MW-1:0]           win_idx;
  logic                    win_valid;
  logic [NUM_MASTERS-1:0]  win_onehot;

  // Beats still to come after the NONSEQ of a fixed-length burst; 0 for INCR.
  function automatic logic [CNT_W-1:0] burst_load(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: burst_load = CNT_W'(3);
      3'b100, 3'b101: burst_load = CNT_W'(7);
      3'b110, 3'b111: burst_load = CNT_W'(15);
      default:        burst_load = '0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Winner selection
  // ---------------------------------------------------------------------------
  always_comb begin : winner_sel
    int idx;
    // NOTE: every variable written in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    max_prio   = '0;
    cand       = '0;
    win_idx    = '0;
    win_valid  = 1'b0;
    win_onehot = '0;
    idx        = 0;

    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hreq[i] && (hprior[i*PRIO_W +: PRIO_W] > max_prio)) begin
        max_prio = hprior[i*PRIO_W +: PRIO_W];
      end
    end

    // Mode 1 ignores priority; the other modes keep only the top-priority
    // requesters as candidates.
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand[i] = hreq[i] && ((ARB_MODE == 1) || (hprior[i*PRIO_W +: PRIO_W] == max_prio));
    end

    if (ARB_MODE == 0) begin
      // Scan downward so the lowest-index candidate is written last.
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (cand[i]) begin
          win_idx   = MW'(i);
          win_valid = 1'b1;
        end
      end
    end else begin
      // Round-robin search upward from rr_ptr with wrap; scanning the offsets
      // in reverse leaves the nearest candidate as the final assignment.
      for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
        if (cand[idx]) begin
          win_idx   = MW'(idx);
          win_valid = 1'b1;
        end
      end
    end

    if (win_valid) win_onehot[win_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin : next_state
    logic rearb;
    state_d      = state_q;
    grant_d      = grant_q;
    grant_data_d = grant_data_q;
    cnt_d        = cnt_q;
    lock_incr_d  = lock_incr_q;
    rr_ptr_d     = rr_ptr_q;
    rearb        = 1'b0;

    // Nothing moves unless the slave accepts the address phase.
    if (hready_in) begin
      grant_data_d = grant_q;

      case (state_q)
        ST_OPEN: begin
          if ((grant_q != '0) && (htrans_in == TR_NONSEQ) && (hburst_in != BU_SINGLE)) begin
            // Current owner starts a burst: keep its grant.
            state_d     = ST_LOCKED;
            cnt_d       = burst_load(hburst_in);
            lock_incr_d = (hburst_in == BU_INCR);
          end else begin
            rearb = 1'b1;
          end
        end

        ST_LOCKED: begin
          if (lock_incr_q) begin
            case (htrans_in)
              TR_SEQ: begin
                if (cnt_q >= INCR_LAST) begin
                  rearb = 1'b1;
                end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
                end
              end
              TR_IDLE, TR_NONSEQ: rearb = 1'b1;
              default: ;  // BUSY holds
            endcase
          end else begin
            // Fixed-length burst: only accepted SEQ beats count down.
            if (htrans_in == TR_SEQ) begin
              if (cnt_q <= CNT_W'(1)) begin
                rearb = 1'b1;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
          end
        end

        default: rearb = 1'b1;
      endcase

      if (rearb) begin
        state_d     = ST_OPEN;
        cnt_d       = '0;
        lock_incr_d = 1'b0;
        grant_d     = win_onehot;
        if (win_valid) begin
          rr_ptr_d = (win_idx == MW'(NUM_MASTERS - 1)) ? '0 : win_idx + MW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    if (!hreset_n) begin
      state_q      <= ST_OPEN;
      grant_q      <= '0;
      grant_data_q <= '0;
      cnt_q        <= '0;
      lock_incr_q  <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_data_q <= grant_data_d;
      cnt_q        <= cnt_d;
      lock_incr_q  <= lock_incr_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin : encode_master
    hmaster = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) hmaster = MW'(i);
    end
  end

  assign hgrant       = grant_q;
  assign hsel         = |grant_q;
  assign hgrant_data  = grant_data_q;
  assign burst_locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_ahb_slave_arbiter_gen.sv
// -----------------------------------------------------------------------------
// tb_ahb_slave_arbiter_gen
//
// Three arbiter instances share one set of inputs:
//   unit 0 : fixed priority, INCR_MAX_BEATS = 16
//   unit 1 : round-robin,    INCR_MAX_BEATS = 16
//   unit 2 : priority + RR,  INCR_MAX_BEATS = 4
// Each scenario drives a table of cycles; the expected outputs of a row are
// queued when the row is driven and popped after the following clock edge.
// -----------------------------------------------------------------------------
module tb_ahb_slave_arbiter_gen;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] BUSY = 2'b01;
  localparam logic [1:0] NSEQ = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] WRAP4  = 3'b010;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] WRAP8  = 3'b100;

  // One clock of stimulus plus the outputs required after that clock edge.
  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [7:0] pri;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       rdy;
    logic [3:0] g;
    logic [3:0] gd;
    logic       lk;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] hreq;
  logic [7:0] hprior;
  logic [1:0] htrans_in;
  logic [2:0] hburst_in;
  logic       hready_in;

  logic [3:0] hgrant_u       [3];
  logic       hsel_u         [3];
  logic [3:0] hgrant_data_u  [3];
  logic [1:0] hmaster_u      [3];
  logic       burst_locked_u [3];

  int vectors    = 0;
  int miscompares = 0;

  // Packed expectation: {hgrant, hgrant_data, burst_locked, hsel, hmaster}.
  logic [11:0] sb [$];

  always #5 clk = ~clk;

  ahb_slave_arbiter_gen #(.NUM_MASTERS(4), .PRIO_W(2), .ARB_MODE(0), .INCR_MAX_BEATS(16)) u0 (
    .hclk(clk), .hreset_n(rst_n), .hreq(hreq), .hprior(hprior), .htrans_in(htrans_in),
    .hburst_in(hburst_in), .hready_in(hready_in), .hgrant(hgrant_u[0]), .hsel(hsel_u[0]),
    .hgrant_data(hgrant_data_u[0]), .hmaster(hmaster_u[0]), .burst_locked(burst_locked_u[0]));

  ahb_slave_arbiter_gen #(.NUM_MASTERS(4), .PRIO_W(2), .ARB_MODE(1), .INCR_MAX_BEATS(16)) u1 (
    .hclk(clk), .hreset_n(rst_n), .hreq(hreq), .hprior(hprior), .htrans_in(htrans_in),
    .hburst_in(hburst_in), .hready_in(hready_in), .hgrant(hgrant_u[1]), .hsel(hsel_u[1]),
    .hgrant_data(hgrant_data_u[1]), .hmaster(hmaster_u[1]), .burst_locked(burst_locked_u[1]));

  ahb_slave_arbiter_gen #(.NUM_MASTERS(4), .PRIO_W(2), .ARB_MODE(2), .INCR_MAX_BEATS(4)) u2 (
    .hclk(clk), .hreset_n(rst_n), .hreq(hreq), .hprior(hprior), .htrans_in(htrans_in),
    .hburst_in(hburst_in), .hready_in(hready_in), .hgrant(hgrant_u[2]), .hsel(hsel_u[2]),
    .hgrant_data(hgrant_data_u[2]), .hmaster(hmaster_u[2]), .burst_locked(burst_locked_u[2]));

  function automatic logic [1:0] enc(input logic [3:0] onehot);
    enc = 2'd0;
    for (int i = 0; i < 4; i++) if (onehot[i]) enc = 2'(i);
  endfunction

  function automatic logic [11:0] expect_of(input step_t s);
    expect_of = {s.g, s.gd, s.lk, |s.g, enc(s.g)};
  endfunction

  function automatic logic [11:0] observe(input int u);
    observe = {hgrant_u[u], hgrant_data_u[u], burst_locked_u[u], hsel_u[u], hmaster_u[u]};
  endfunction

  task automatic drive(input step_t s);
    rst_n     = s.rst;
    hreq      = s.req;
    hprior    = s.pri;
    htrans_in = s.tr;
    hburst_in = s.bu;
    hready_in = s.rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hreq = '0; hprior = '0; htrans_in = IDLE; hburst_in = SINGLE; hready_in = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst_n = 1'b0; hreq = 4'b1111; hprior = 8'hff; htrans_in = NSEQ; hburst_in = INCR; hready_in = 1'b1;
    for (int u = 0; u < 3; u++) sb.push_back(12'h000);
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) begin
      got = observe(u);
      vectors++;
      if (got !== sb.pop_front()) begin
        miscompares++;
        $display("FAIL reset unit %0d: got %b required 000000000000", u, got);
      end
    end
    rst_n = 1'b1;
  endtask

  // Mode 0: priority, then lowest index on ties, then empty request.
  task automatic test_fixed_priority();
    step_t s [6];
    logic [11:0] got, want;
    s = '{
      '{1'b1, 4'b0110, 8'b00_01_11_00, IDLE, SINGLE, 1'b1, 4'b0010, 4'b0000, 1'b0},
      '{1'b1, 4'b0110, 8'b00_01_11_00, IDLE, SINGLE, 1'b1, 4'b0010, 4'b0010, 1'b0},
      '{1'b1, 4'b1100, 8'b10_10_00_00, IDLE, SINGLE, 1'b1, 4'b0100, 4'b0010, 1'b0},
      '{1'b1, 4'b0000, 8'b10_10_00_00, IDLE, SINGLE, 1'b1, 4'b0000, 4'b0100, 1'b0},
      '{1'b1, 4'b1001, 8'b00_00_00_00, IDLE, SINGLE, 1'b1, 4'b0001, 4'b0000, 1'b0},
      '{1'b1, 4'b1001, 8'b01_00_00_00, IDLE, SINGLE, 1'b1, 4'b1000, 4'b0001, 1'b0}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(s[i]);
      sb.push_back(expect_of(s[i]));
      @(posedge clk); #1;
      got = observe(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL fixed_priority step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  // Mode 1: rotation over all requesters, then skipping idle masters.
  task automatic test_round_robin();
    step_t s [8];
    logic [11:0] got, want;
    s = '{
      '{1'b1, 4'b1111, 8'b11_00_00_00, NSEQ, SINGLE, 1'b1, 4'b0001, 4'b0000, 1'b0},
      '{1'b1, 4'b1111, 8'b11_00_00_00, NSEQ, SINGLE, 1'b1, 4'b0010, 4'b0001, 1'b0},
      '{1'b1, 4'b1111, 8'b11_00_00_00, NSEQ, SINGLE, 1'b1, 4'b0100, 4'b0010, 1'b0},
      '{1'b1, 4'b1111, 8'b11_00_00_00, NSEQ, SINGLE, 1'b1, 4'b1000, 4'b0100, 1'b0},
      '{1'b1, 4'b1111, 8'b11_00_00_00, NSEQ, SINGLE, 1'b1, 4'b0001, 4'b1000, 1'b0},
      '{1'b1, 4'b1010, 8'b11_00_00_00, NSEQ, SINGLE, 1'b1, 4'b0010, 4'b0001, 1'b0},
      '{1'b1, 4'b1010, 8'b11_00_00_00, NSEQ, SINGLE, 1'b1, 4'b1000, 4'b0010, 1'b0},
      '{1'b1, 4'b1010, 8'b11_00_00_00, NSEQ, SINGLE, 1'b1, 4'b0010, 4'b1000, 1'b0}};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      sb.push_back(expect_of(s[i]));
      @(posedge clk); #1;
      got = observe(1); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL round_robin step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  // INCR4 owned by master 2; master 0 (prio 3) asks mid-burst while master 2
  // withdraws its request; a BUSY beat does not count.
  task automatic test_fixed_burst_lock();
    step_t s [7];
    logic [11:0] got, want;
    s = '{
      '{1'b1, 4'b0100, 8'b00_00_00_00, IDLE, SINGLE, 1'b1, 4'b0100, 4'b0000, 1'b0},
      '{1'b1, 4'b0100, 8'b00_00_00_00, NSEQ, INCR4,  1'b1, 4'b0100, 4'b0100, 1'b1},
      '{1'b1, 4'b0001, 8'b00_00_00_11, SEQ,  INCR4,  1'b1, 4'b0100, 4'b0100, 1'b1},
      '{1'b1, 4'b0001, 8'b00_00_00_11, BUSY, INCR4,  1'b1, 4'b0100, 4'b0100, 1'b1},
      '{1'b1, 4'b0001, 8'b00_00_00_11, SEQ,  INCR4,  1'b1, 4'b0100, 4'b0100, 1'b1},
      '{1'b1, 4'b0001, 8'b00_00_00_11, SEQ,  INCR4,  1'b1, 4'b0001, 4'b0100, 1'b0},
      '{1'b1, 4'b0001, 8'b00_00_00_11, IDLE, SINGLE, 1'b1, 4'b0001, 4'b0001, 1'b0}};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(s[i]);
      sb.push_back(expect_of(s[i]));
      @(posedge clk); #1;
      got = observe(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL fixed_burst_lock step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  // WRAP4 with three stalled cycles mid-burst while hreq toggles; the burst
  // must still end exactly after its third SEQ. A stall in OPEN also holds.
  task automatic test_stall_hold();
    step_t s [10];
    logic [11:0] got, want;
    s = '{
      '{1'b1, 4'b0010, 8'h00, IDLE, SINGLE, 1'b1, 4'b0010, 4'b0000, 1'b0},
      '{1'b1, 4'b0010, 8'h00, NSEQ, WRAP4,  1'b1, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b0010, 8'h00, SEQ,  WRAP4,  1'b1, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b1101, 8'h00, SEQ,  WRAP4,  1'b0, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b0000, 8'h00, SEQ,  WRAP4,  1'b0, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b1111, 8'h00, SEQ,  WRAP4,  1'b0, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b1000, 8'h00, SEQ,  WRAP4,  1'b1, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b1000, 8'h00, SEQ,  WRAP4,  1'b1, 4'b1000, 4'b0010, 1'b0},
      '{1'b1, 4'b0001, 8'h00, IDLE, SINGLE, 1'b0, 4'b1000, 4'b0010, 1'b0},
      '{1'b1, 4'b0001, 8'h00, IDLE, SINGLE, 1'b1, 4'b0001, 4'b1000, 1'b0}};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(s[i]);
      sb.push_back(expect_of(s[i]));
      @(posedge clk); #1;
      got = observe(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL stall_hold step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  // Mode 2 with INCR_MAX_BEATS=4: forced release after the 4th SEQ hands the
  // port to the tied master 3; NONSEQ and IDLE end INCR locks; priority beats RR.
  task automatic test_incr_release();
    step_t s [13];
    logic [11:0] got, want;
    s = '{
      '{1'b1, 4'b1010, 8'b10_00_10_00, IDLE, SINGLE, 1'b1, 4'b0010, 4'b0000, 1'b0},
      '{1'b1, 4'b1010, 8'b10_00_10_00, NSEQ, INCR,   1'b1, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b1010, 8'b10_00_10_00, SEQ,  INCR,   1'b1, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b1010, 8'b10_00_10_00, SEQ,  INCR,   1'b1, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b1010, 8'b10_00_10_00, BUSY, INCR,   1'b1, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b1010, 8'b10_00_10_00, SEQ,  INCR,   1'b1, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b1010, 8'b10_00_10_00, SEQ,  INCR,   1'b1, 4'b1000, 4'b0010, 1'b0},
      '{1'b1, 4'b1010, 8'b10_00_10_00, NSEQ, INCR,   1'b1, 4'b1000, 4'b1000, 1'b1},
      '{1'b1, 4'b1010, 8'b10_00_10_00, SEQ,  INCR,   1'b1, 4'b1000, 4'b1000, 1'b1},
      '{1'b1, 4'b1010, 8'b10_00_10_00, NSEQ, INCR,   1'b1, 4'b0010, 4'b1000, 1'b0},
      '{1'b1, 4'b0010, 8'b10_00_10_00, NSEQ, INCR,   1'b1, 4'b0010, 4'b0010, 1'b1},
      '{1'b1, 4'b0000, 8'b10_00_10_00, IDLE, SINGLE, 1'b1, 4'b0000, 4'b0010, 1'b0},
      '{1'b1, 4'b1010, 8'b10_00_11_00, IDLE, SINGLE, 1'b1, 4'b0010, 4'b0000, 1'b0}};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(s[i]);
      sb.push_back(expect_of(s[i]));
      @(posedge clk); #1;
      got = observe(2); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL incr_release step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  // Reset in the middle of a WRAP8, then a fresh INCR4 lock follows OPEN rules.
  task automatic test_reset_mid_burst();
    step_t s [10];
    logic [11:0] got, want;
    s = '{
      '{1'b1, 4'b0001, 8'h00, IDLE, SINGLE, 1'b1, 4'b0001, 4'b0000, 1'b0},
      '{1'b1, 4'b0001, 8'h00, NSEQ, WRAP8,  1'b1, 4'b0001, 4'b0001, 1'b1},
      '{1'b1, 4'b0001, 8'h00, SEQ,  WRAP8,  1'b1, 4'b0001, 4'b0001, 1'b1},
      '{1'b1, 4'b0001, 8'h00, SEQ,  WRAP8,  1'b1, 4'b0001, 4'b0001, 1'b1},
      '{1'b0, 4'b0001, 8'h00, SEQ,  WRAP8,  1'b1, 4'b0000, 4'b0000, 1'b0},
      '{1'b1, 4'b0100, 8'h00, SEQ,  WRAP8,  1'b1, 4'b0100, 4'b0000, 1'b0},
      '{1'b1, 4'b0100, 8'h00, NSEQ, INCR4,  1'b1, 4'b0100, 4'b0100, 1'b1},
      '{1'b1, 4'b0001, 8'h00, SEQ,  INCR4,  1'b1, 4'b0100, 4'b0100, 1'b1},
      '{1'b1, 4'b0001, 8'h00, SEQ,  INCR4,  1'b1, 4'b0100, 4'b0100, 1'b1},
      '{1'b1, 4'b0001, 8'h00, SEQ,  INCR4,  1'b1, 4'b0001, 4'b0100, 1'b0}};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(s[i]);
      sb.push_back(expect_of(s[i]));
      @(posedge clk); #1;
      got = observe(0); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL reset_mid_burst step %0d: got %b required %b", i, got, want);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; hreq = '0; hprior = '0; htrans_in = IDLE; hburst_in = SINGLE; hready_in = 1'b1;
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_fixed_burst_lock();
    test_stall_hold();
    test_incr_release();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
